pcg_dither_mixer: RTL and testbench

PCG_DITHER_MIXER -- requirements
Module: pcg_dither_mixer

---
 rtl/pcg_dither_mixer.sv | 109 ++++++++++
 tb/tb_pcg_dither_mixer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pcg_dither_mixer.sv
// PCG-style noise generator (LCG state + xorshift + rotate) feeding a
// registered per-bit dither mixer for pixel/sync words.
module pcg_dither_mixer #(
    parameter int          STATE_W = 16,
    parameter int          OUT_W   = 8,
    parameter logic [63:0] MULT    = 64'h5851,
    parameter logic [63:0] INC     = 64'h1405
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_en,
    input  logic               seed_valid,
    output logic               seed_ready,
    input  logic [STATE_W-1:0] seed_data,
    output logic [OUT_W-1:0]   rnd_out,
    output logic               rnd_valid,
    input  logic [OUT_W-1:0]   pix_in,
    input  logic [OUT_W-1:0]   mask,
    input  logic [1:0]         mode,
    output logic [OUT_W-1:0]   pix_out
);

    localparam int ROT_W = $clog2(OUT_W);
    localparam int XS_SH = STATE_W - OUT_W - ROT_W;
    localparam int Q_SH  = STATE_W / 4;
    localparam logic [STATE_W-1:0] MULT_W = MULT[STATE_W-1:0];
    localparam logic [STATE_W-1:0] INC_W  = INC[STATE_W-1:0];

    typedef enum logic [1:0] {RUN, HOLD, LOAD} fsm_t;

    fsm_t               fsm;
    logic [STATE_W-1:0] state_p0;
    logic [OUT_W-1:0]   xs_p1;
    logic [ROT_W-1:0]   rot_p1;
    logic               vld_p1;
    logic               vld_p2;

    logic               seed_acc;
    logic               step;
    logic [STATE_W-1:0] xmix;
    logic [OUT_W-1:0]   xs_nxt;
    logic [ROT_W-1:0]   rot_nxt;

    function automatic logic [OUT_W-1:0] rotr(input logic [OUT_W-1:0] x,
                                              input logic [ROT_W-1:0] r);
        logic [2*OUT_W-1:0] dbl;
        dbl = {x, x} >> r;
        return dbl[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] mix_pix(input logic [OUT_W-1:0] p,
                                                 input logic [OUT_W-1:0] m,
                                                 input logic [OUT_W-1:0] n,
                                                 input logic [1:0]       md);
        case (md)
            2'b00:   return p;
            2'b01:   return p ^ (n & m);
            2'b10:   return p | (n & m);
            default: return (p & ~m) | (n & m);
        endcase
    endfunction

    // A seed always wins over stepping; LOAD is a dead cycle for the generator.
    assign seed_acc = seed_valid & seed_ready;
    assign step     = step_en & ~seed_acc & (fsm != LOAD);

    assign xmix    = ((state_p0 >> Q_SH) ^ state_p0) >> XS_SH;
    assign xs_nxt  = xmix[OUT_W-1:0];
    assign rot_nxt = state_p0[STATE_W-1 -: ROT_W];

    assign rnd_valid = vld_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= HOLD;
            seed_ready <= 1'b1;
            state_p0   <= '0;
            xs_p1      <= '0;
            rot_p1     <= '0;
            rnd_out    <= '0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            pix_out    <= '0;
        end else begin
            // mixer stage: noise is forced to zero until the stream is valid
            pix_out <= mix_pix(pix_in, mask, (vld_p2 ? rnd_out : '0), mode);
            if (seed_acc) begin
                fsm        <= LOAD;
                seed_ready <= 1'b0;
                state_p0   <= seed_data;
                vld_p1     <= 1'b0;
                vld_p2     <= 1'b0;
            end else begin
                fsm        <= step_en ? RUN : HOLD;
                seed_ready <= 1'b1;
                if (step) begin
                    // p0 -> p1 -> p2 advance together; a stall freezes all three
                    state_p0 <= state_p0 * MULT_W + INC_W;
                    xs_p1    <= xs_nxt;
                    rot_p1   <= rot_nxt;
                    rnd_out  <= rotr(xs_p1, rot_p1);
                    vld_p1   <= 1'b1;
                    vld_p2   <= vld_p1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcg_dither_mixer.sv
// Directed bench for pcg_dither_mixer: default 16/8 build with hand-computed
// words, plus a 32/16 build compared against a small reference model.
module tb_pcg_dither_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, step_en, seed_valid, seed_ready, rnd_valid;
    logic [15:0] seed_data;
    logic [7:0]  rnd_out, pix_in, mask, pix_out;
    logic [1:0]  mode;

    logic        b_rst_n, b_step_en, b_seed_valid, b_seed_ready, b_rnd_valid;
    logic [31:0] b_seed_data;
    logic [15:0] b_rnd_out, b_pix_in, b_mask, b_pix_out;
    logic [1:0]  b_mode;

    int checks = 0;
    int errors = 0;

    pcg_dither_mixer dut (
        .clk(clk), .rst_n(rst_n), .step_en(step_en),
        .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data),
        .rnd_out(rnd_out), .rnd_valid(rnd_valid),
        .pix_in(pix_in), .mask(mask), .mode(mode), .pix_out(pix_out)
    );

    pcg_dither_mixer #(.STATE_W(32), .OUT_W(16)) dut32 (
        .clk(clk), .rst_n(b_rst_n), .step_en(b_step_en),
        .seed_valid(b_seed_valid), .seed_ready(b_seed_ready), .seed_data(b_seed_data),
        .rnd_out(b_rnd_out), .rnd_valid(b_rnd_valid),
        .pix_in(b_pix_in), .mask(b_mask), .mode(b_mode), .pix_out(b_pix_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m32_next(input logic [31:0] s);
        return s * 32'h0000_5851 + 32'h0000_1405;
    endfunction

    function automatic logic [15:0] m32_word(input logic [31:0] s);
        logic [31:0] t;
        logic [15:0] x;
        logic [15:0] y;
        int          r;
        t = s ^ {8'h00, s[31:8]};
        x = t[27:12];
        r = int'(s[31:28]);
        y = x;
        for (int i = 0; i < r; i++) y = {y[0], y[15:1]};
        return y;
    endfunction

    initial begin
        logic [31:0] ms;
        rst_n = 1'b0; step_en = 1'b0; seed_valid = 1'b0; seed_data = '0;
        pix_in = '0; mask = '0; mode = 2'b00;
        b_rst_n = 1'b0; b_step_en = 1'b0; b_seed_valid = 1'b0; b_seed_data = '0;
        b_pix_in = 16'h1234; b_mask = 16'h0000; b_mode = 2'b01;
        tick(); tick();
        check("rst_rnd_out", 32'(rnd_out), 32'h00);
        check("rst_rnd_valid", 32'(rnd_valid), 32'h0);
        check("rst_pix_out", 32'(pix_out), 32'h00);
        check("rst_seed_ready", 32'(seed_ready), 32'h1);

        // free-running stream from reset, with noise still invalid for mixing
        rst_n = 1'b1; step_en = 1'b1; pix_in = 8'h5A; mask = 8'hFF; mode = 2'b11;
        tick();
        check("run_e1_valid", 32'(rnd_valid), 32'h0);
        check("mix_invalid_replace", 32'(pix_out), 32'h00);
        mode = 2'b01;
        tick();
        check("run_e2_valid", 32'(rnd_valid), 32'h1);
        check("run_e2_word", 32'(rnd_out), 32'h00);
        check("mix_invalid_xor", 32'(pix_out), 32'h5A);
        tick();
        check("run_e3_word", 32'(rnd_out), 32'hAA);

        // stall for 5 cycles while exercising every mix mode against n=0xAA
        step_en = 1'b0; pix_in = 8'h0F; mask = 8'hFF; mode = 2'b00;
        tick();
        check("mix_pass", 32'(pix_out), 32'h0F);
        check("hold1_word", 32'(rnd_out), 32'hAA);
        check("hold1_valid", 32'(rnd_valid), 32'h1);
        mode = 2'b01;
        tick();
        check("mix_xor", 32'(pix_out), 32'hA5);
        mode = 2'b10;
        tick();
        check("mix_or", 32'(pix_out), 32'hAF);
        mode = 2'b11; mask = 8'hF0;
        tick();
        check("mix_replace_f0", 32'(pix_out), 32'hAF);
        mode = 2'b11; mask = 8'hFF;
        tick();
        check("mix_replace_ff", 32'(pix_out), 32'hAA);
        check("hold5_word", 32'(rnd_out), 32'hAA);
        check("hold5_valid", 32'(rnd_valid), 32'h1);
        step_en = 1'b1; mode = 2'b00;
        tick();
        check("resume_word1", 32'(rnd_out), 32'h0E);
        tick();
        check("resume_word2", 32'(rnd_out), 32'hFB);

        // seed load while stepping
        seed_valid = 1'b1; seed_data = 16'h1405;
        tick();
        seed_valid = 1'b0;
        check("seed_ready_load", 32'(seed_ready), 32'h0);
        check("seed_valid_a", 32'(rnd_valid), 32'h0);
        check("seed_rnd_hold", 32'(rnd_out), 32'hFB);
        tick();
        check("seed_ready_back", 32'(seed_ready), 32'h1);
        check("seed_valid_b", 32'(rnd_valid), 32'h0);
        tick();
        check("seed_valid_c", 32'(rnd_valid), 32'h0);
        tick();
        check("seed_valid_d", 32'(rnd_valid), 32'h1);
        check("seed_word1", 32'(rnd_out), 32'hAA);
        tick();
        check("seed_word2", 32'(rnd_out), 32'h0E);

        // reset asserted while in LOAD
        seed_valid = 1'b1; seed_data = 16'hBEEF;
        tick();
        seed_valid = 1'b0;
        check("load2_seed_ready", 32'(seed_ready), 32'h0);
        rst_n = 1'b0;
        tick();
        check("rstload_rnd_out", 32'(rnd_out), 32'h00);
        check("rstload_valid", 32'(rnd_valid), 32'h0);
        check("rstload_pix_out", 32'(pix_out), 32'h00);
        check("rstload_seed_ready", 32'(seed_ready), 32'h1);
        rst_n = 1'b1; step_en = 1'b1;
        tick();
        check("restart_e1_valid", 32'(rnd_valid), 32'h0);
        check("restart_e1_ready", 32'(seed_ready), 32'h1);
        tick();
        check("restart_e2_valid", 32'(rnd_valid), 32'h1);
        check("restart_e2_word", 32'(rnd_out), 32'h00);
        tick();
        check("restart_e3_word", 32'(rnd_out), 32'hAA);

        // 32/16 build: seed at all-ones so the first step wraps
        b_rst_n = 1'b1; b_seed_valid = 1'b1; b_seed_data = 32'hFFFF_FFFF; b_step_en = 1'b1;
        tick();
        b_seed_valid = 1'b0;
        check("w32_seed_ready", 32'(b_seed_ready), 32'h0);
        tick();
        tick();
        check("w32_valid_pre", 32'(b_rnd_valid), 32'h0);
        tick();
        check("w32_valid", 32'(b_rnd_valid), 32'h1);
        check("w32_word0", 32'(b_rnd_out), 32'hE001);
        check("w32_pix_pass", 32'(b_pix_out), 32'h1234);
        tick();
        check("w32_word1_wrap", 32'(b_rnd_out), 32'hE009);
        ms = m32_next(m32_next(32'hFFFF_FFFF));
        for (int i = 0; i < 3000; i++) begin
            tick();
            check("w32_stream", 32'(b_rnd_out), 32'(m32_word(ms)));
            check("w32_stream_valid", 32'(b_rnd_valid), 32'h1);
            ms = m32_next(ms);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
